// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP host port: register map, step codes, FIFO entry and access states.
package vdp_pkg;
    localparam logic [1:0] REG_ADDR_LO = 2'd0;
    localparam logic [1:0] REG_ADDR_HI = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam logic [1:0] STEP_0  = 2'd0;
    localparam logic [1:0] STEP_1  = 2'd1;
    localparam logic [1:0] STEP_2  = 2'd2;
    localparam logic [1:0] STEP_80 = 2'd3;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } acc_state_t;

    function automatic logic [ADDR_W-1:0] step_value(input logic [1:0] code);
        case (code)
            STEP_0:  return 15'd0;
            STEP_1:  return 15'd1;
            STEP_2:  return 15'd2;
            default: return 15'd80;
        endcase
    endfunction
endpackage

// File: rtl/vdp_wfifo.sv
// Small synchronous FIFO; a push on a full FIFO is accepted when a pop happens in the same cycle.
module vdp_wfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/vdp_host_port.sv
// Host register port of the VDP: address pointer, write FIFO and VRAM access sequencer.
// Optional VRAM read-back path (prefetch buffer) is enabled with VDP_HOST_READ_EN.
module vdp_host_port
    import vdp_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 host_cs,
    input  logic                 host_we,
    input  logic [1:0]           host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 vram_req,
    output logic                 vram_we,
    output logic [ADDR_W-1:0]    vram_addr,
    output logic [7:0]           vram_wdata,
    input  logic                 vram_ack,
    input  logic [7:0]           vram_rdata
);
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        step;
    logic              ovf, rvalid, pending;
    logic [7:0]        rd_data;
    logic              ptr_adv_rd;
    acc_state_t        state, state_d;
    logic              launch_wr, launch_rd;
    wr_entry_t         head, push_entry;
    logic              full, empty, pop, push_ok;
    logic              host_wr, host_rd, data_wr, lo_wr, hi_wr;
    logic [7:0]        status;

    assign host_wr    = host_cs && host_we;
    assign host_rd    = host_cs && !host_we;
    assign data_wr    = host_wr && (host_addr == REG_DATA);
    assign lo_wr      = host_wr && (host_addr == REG_ADDR_LO);
    assign hi_wr      = host_wr && (host_addr == REG_ADDR_HI);
    assign pop        = (state == ST_WRITE) && vram_ack;
    assign push_ok    = data_wr && (!full || pop);
    assign push_entry = '{addr: ptr, data: host_wdata};
    assign status     = {4'b0, ovf, rvalid, full, empty};

    vdp_wfifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

`ifdef VDP_HOST_READ_EN
    logic data_rd, trigger, rd_done;
    logic [7:0] rbuf;

    assign data_rd    = host_rd && (host_addr == REG_DATA);
    // Moving the pointer under an in-flight read makes its result stale; re-arm instead.
    assign trigger    = hi_wr || data_rd || ((lo_wr || hi_wr) && state == ST_READ);
    assign rd_done    = (state == ST_READ) && vram_ack;
    assign rd_data    = rbuf;
    assign ptr_adv_rd = data_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            rvalid  <= 1'b0;
            rbuf    <= 8'h00;
        end else begin
            if (trigger)        pending <= 1'b1;
            else if (launch_rd) pending <= 1'b0;
            if (trigger) begin
                rvalid <= 1'b0;
            end else if (rd_done && !pending) begin
                rvalid <= 1'b1;
                rbuf   <= vram_rdata;
            end
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^vram_rdata;
    assign pending      = 1'b0;
    assign rvalid       = 1'b0;
    assign rd_data      = 8'h00;
    assign ptr_adv_rd   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr  <= '0;
            step <= STEP_0;
            ovf  <= 1'b0;
        end else begin
            if (lo_wr)                        ptr[7:0]  <= host_wdata;
            else if (hi_wr)                   ptr[14:8] <= host_wdata[6:0];
            else if (push_ok || ptr_adv_rd)   ptr       <= ptr + step_value(step);
            if (host_wr && host_addr == REG_CTRL) step <= host_wdata[1:0];
            if (data_wr && !push_ok)                    ovf <= 1'b1;
            else if (host_rd && host_addr == REG_CTRL)  ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata <= 8'h00;
        end else if (host_rd) begin
            case (host_addr)
                REG_ADDR_LO: host_rdata <= ptr[7:0];
                REG_ADDR_HI: host_rdata <= {1'b0, ptr[14:8]};
                REG_DATA:    host_rdata <= rd_data;
                default:     host_rdata <= status;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        launch_wr = 1'b0;
        launch_rd = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_d   = ST_WRITE;
                    launch_wr = 1'b1;
                end else if (pending) begin
                    state_d   = ST_READ;
                    launch_rd = 1'b1;
                end
            end
            ST_WRITE: if (vram_ack) state_d = ST_IDLE;
            ST_READ:  if (vram_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
        end else begin
            state <= state_d;
            // Request fields only change on launch, so they hold steady until the ack.
            if (launch_wr) begin
                vram_we    <= 1'b1;
                vram_addr  <= head.addr;
                vram_wdata <= head.data;
            end else if (launch_rd) begin
                vram_we    <= 1'b0;
                vram_addr  <= ptr;
            end
        end
    end

    assign vram_req = (state != ST_IDLE);
endmodule

// File: tb/tb_vdp_host_port.sv
// Directed bench for vdp_host_port: vector table of host accesses plus hand-written corner sequences.
module tb_vdp_host_port;
    import vdp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_cs, host_we;
    logic [1:0]  host_addr;
    logic [7:0]  host_wdata, host_rdata;
    logic        vram_req, vram_we, vram_ack;
    logic [14:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;

    always #5 clk = ~clk;

    vdp_host_port dut (
        .clk(clk), .reset(reset), .host_cs(host_cs), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
    );

`ifdef VDP_HOST_READ_EN
    localparam logic [7:0] RV = 8'h04;
`else
    localparam logic [7:0] RV = 8'h00;
`endif

    typedef struct { logic [14:0] addr; logic [7:0] data; } xact_t;
    typedef enum { OP_W, OP_R, OP_IDLE, OP_ACK } op_e;
    typedef struct { op_e op; logic [1:0] a; logic [7:0] d; logic [7:0] exp; string name; } vec_t;

    xact_t       wlog[$], rlog[$];
    logic [7:0]  mem [logic [14:0]];
    vec_t        vecs[$];
    int          total = 0, passed = 0, proto_err = 0, ack_cnt = 0;
    bit          ack_en = 0;
    logic        prev_req = 0, prev_we = 0;
    logic [14:0] prev_addr = '0;
    logic [7:0]  prev_wd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: log the ack'd transfer, advance to the next falling edge, check protocol, respond.
    task automatic cycle();
        if (vram_req && vram_ack) begin
            if (vram_we) begin
                wlog.push_back('{vram_addr, vram_wdata});
                mem[vram_addr] = vram_wdata;
            end else begin
                rlog.push_back('{vram_addr, 8'h00});
            end
        end
        @(posedge clk);
        @(negedge clk);
`ifndef VDP_HOST_READ_EN
        if (vram_req && !vram_we) proto_err++;
`endif
        if (prev_req && !vram_ack && reset &&
            (!vram_req || vram_we !== prev_we || vram_addr !== prev_addr || vram_wdata !== prev_wd))
            proto_err++;
        prev_req  = vram_req && reset;
        prev_we   = vram_we;
        prev_addr = vram_addr;
        prev_wd   = vram_wdata;
        if (ack_en) begin
            if (vram_ack) begin
                vram_ack = 1'b0;
                ack_cnt  = 0;
            end else if (vram_req) begin
                ack_cnt++;
                if (ack_cnt >= 2) begin
                    vram_ack   = 1'b1;
                    vram_rdata = mem.exists(vram_addr) ? mem[vram_addr] : 8'h00;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        host_cs = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        cycle();
        host_cs = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, output logic [7:0] d);
        host_cs = 1'b1; host_we = 1'b0; host_addr = a;
        cycle();
        host_cs = 1'b0;
        d = host_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    function automatic vec_t v(op_e op, logic [1:0] a, logic [7:0] d, logic [7:0] e, string n);
        vec_t r;
        r.op = op; r.a = a; r.d = d; r.exp = e; r.name = n;
        return r;
    endfunction

    task automatic check_wlog(input string name, input logic [14:0] ea [], input logic [7:0] ed []);
        check({name, "_count"}, 32'(wlog.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wlog.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(wlog[i].addr), 32'(ea[i]));
            check($sformatf("%s_data%0d", name, i), 32'(wlog[i].data), 32'(ed[i]));
        end
    endtask

    initial begin
        logic [7:0] rd;
        bit         saw_req;

        reset = 1'b0; host_cs = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        vram_ack = 0; vram_rdata = '0;

        // Basic writes, overflow, pointer wrap with step 80.
        vecs.push_back(v(OP_ACK,  2'd0, 8'd1, 8'h00, "ack_on"));
        vecs.push_back(v(OP_W, REG_ADDR_HI, 8'h01, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_ADDR_LO, 8'h00, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_CTRL,    8'h01, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_DATA,    8'hAA, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_DATA,    8'hBB, 8'h00, ""));
        vecs.push_back(v(OP_IDLE, 2'd0, 8'd40, 8'h00, ""));
        vecs.push_back(v(OP_R, REG_ADDR_LO, 8'h00, 8'h02, "a_ptr_lo"));
        vecs.push_back(v(OP_R, REG_ADDR_HI, 8'h00, 8'h01, "a_ptr_hi"));
        vecs.push_back(v(OP_R, REG_CTRL,    8'h00, 8'h01 | RV, "a_status"));
        vecs.push_back(v(OP_ACK,  2'd0, 8'd0, 8'h00, "ack_off"));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(v(OP_W, REG_DATA, 8'(i), 8'h00, ""));
        vecs.push_back(v(OP_R, REG_CTRL,    8'h00, 8'h0A | RV, "b_status_ovf"));
        vecs.push_back(v(OP_R, REG_CTRL,    8'h00, 8'h02 | RV, "b_status_clr"));
        vecs.push_back(v(OP_R, REG_ADDR_LO, 8'h00, 8'h06, "b_ptr_lo"));
        vecs.push_back(v(OP_ACK,  2'd0, 8'd1, 8'h00, "ack_on"));
        vecs.push_back(v(OP_IDLE, 2'd0, 8'd40, 8'h00, ""));
        vecs.push_back(v(OP_R, REG_CTRL,    8'h00, 8'h01 | RV, "b_status_drained"));
        vecs.push_back(v(OP_W, REG_ADDR_HI, 8'h7F, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_ADDR_LO, 8'hFF, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_CTRL,    8'h03, 8'h00, ""));
        vecs.push_back(v(OP_W, REG_DATA,    8'h55, 8'h00, ""));
        vecs.push_back(v(OP_IDLE, 2'd0, 8'd20, 8'h00, ""));
        vecs.push_back(v(OP_R, REG_ADDR_LO, 8'h00, 8'h4F, "d_ptr_lo"));
        vecs.push_back(v(OP_R, REG_ADDR_HI, 8'h00, 8'h00, "d_ptr_hi"));
        vecs.push_back(v(OP_R, REG_CTRL,    8'h00, 8'h01 | RV, "d_status"));

        idle(3);
        @(negedge clk); #1;
        check("rst_rdata", 32'(host_rdata), 32'h00);
        check("rst_req",   32'(vram_req),   32'h0);
        check("rst_we",    32'(vram_we),    32'h0);
        check("rst_addr",  32'(vram_addr),  32'h0000);
        check("rst_wdata", 32'(vram_wdata), 32'h00);
        reset = 1'b1;
        idle(2);
        host_read(REG_CTRL, rd);
        check("rst_status", 32'(rd), 32'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_W:    host_write(vecs[i].a, vecs[i].d);
                OP_R:    begin host_read(vecs[i].a, rd); check(vecs[i].name, 32'(rd), 32'(vecs[i].exp)); end
                OP_IDLE: idle(int'(vecs[i].d));
                default: begin ack_en = vecs[i].d[0]; ack_cnt = 0; end
            endcase
        end
        check_wlog("tbl", '{15'h0100, 15'h0101, 15'h0102, 15'h0103, 15'h0104, 15'h0105, 15'h7FFF},
                          '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55});

        // Full FIFO: push and pop in the same cycle both take effect.
        wlog.delete();
        host_write(REG_CTRL, 8'h01);
        ack_en = 0;
        foreach (wlog[i]) ;
        host_write(REG_DATA, 8'h11);
        host_write(REG_DATA, 8'h22);
        host_write(REG_DATA, 8'h33);
        host_write(REG_DATA, 8'h44);
        idle(2);
        check("c_req_up", 32'(vram_req), 32'h1);
        vram_ack = 1'b1;
        host_write(REG_DATA, 8'hCC);
        vram_ack = 1'b0;
        host_read(REG_CTRL, rd);
        check("c_status_full_no_ovf", 32'(rd), 32'(8'h02 | RV));
        host_read(REG_ADDR_LO, rd);
        check("c_ptr_lo", 32'(rd), 32'h54);
        ack_en = 1; ack_cnt = 0;
        idle(40);
        check_wlog("c", '{15'h004F, 15'h0050, 15'h0051, 15'h0052, 15'h0053},
                        '{8'h11, 8'h22, 8'h33, 8'h44, 8'hCC});

        // Reset during an outstanding access, with a late ack mid-reset.
        ack_en = 0;
        host_write(REG_DATA, 8'h77);
        for (int i = 0; i < 10 && !vram_req; i++) cycle();
        check("e_req_up", 32'(vram_req), 32'h1);
        reset = 1'b0;
        #1;
        check("e_req_async", 32'(vram_req), 32'h0);
        vram_ack = 1'b1;
        cycle();
        vram_ack = 1'b0;
        cycle();
        check("e_rdata", 32'(host_rdata), 32'h00);
        check("e_we",    32'(vram_we),    32'h0);
        check("e_addr",  32'(vram_addr),  32'h0000);
        check("e_wdata", 32'(vram_wdata), 32'h00);
        reset = 1'b1;
        ack_en = 1; ack_cnt = 0;
        saw_req = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            saw_req |= vram_req;
        end
        check("e_no_req", 32'(saw_req), 32'h0);
        host_read(REG_CTRL, rd);
        check("e_status", 32'(rd), 32'h01);
        host_read(REG_ADDR_LO, rd);
        check("e_ptr_lo", 32'(rd), 32'h00);

        rlog.delete();
`ifdef VDP_HOST_READ_EN
        host_write(REG_CTRL, 8'h01);
        mem[15'h0200] = 8'h3C;
        mem[15'h0201] = 8'h5A;
        host_write(REG_ADDR_LO, 8'h00);
        host_write(REG_ADDR_HI, 8'h02);
        idle(20);
        check("f_rd_count1", 32'(rlog.size()), 32'd1);
        if (rlog.size() >= 1) check("f_rd_addr0", 32'(rlog[0].addr), 32'h0200);
        host_read(REG_CTRL, rd);
        check("f_status_rvalid", 32'(rd), 32'h05);
        host_read(REG_DATA, rd);
        check("f_data0", 32'(rd), 32'h3C);
        idle(20);
        check("f_rd_count2", 32'(rlog.size()), 32'd2);
        if (rlog.size() >= 2) check("f_rd_addr1", 32'(rlog[1].addr), 32'h0201);
        host_read(REG_DATA, rd);
        check("f_data1", 32'(rd), 32'h5A);
        host_read(REG_ADDR_LO, rd);
        check("f_ptr_lo", 32'(rd), 32'h02);
`else
        host_read(REG_DATA, rd);
        check("f_data_read_zero", 32'(rd), 32'h00);
        host_read(REG_CTRL, rd);
        check("f_status_no_rvalid", 32'(rd), 32'h01);
        idle(10);
        check("f_no_reads", 32'(rlog.size()), 32'd0);
`endif
        check("protocol_errors", 32'(proto_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
